// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache between the
// pipeline MEM stage and data_memory. A hit is answered in the same cycle. A
// miss stalls the CPU while a dirty victim is written back and the line is
// refilled from memory.
//
// Handshake: the CPU raises CPU_READ or CPU_WRITE and holds address and data
// stable for as long as CPU_BUSYWAIT is 1. The access completes in the first
// cycle where CPU_BUSYWAIT is 0. On the memory side the cache raises exactly
// one of MEM_READ / MEM_WRITE and holds MEM_ADDRESS / MEM_WRITE_DATA stable.
// A transfer ends on the posedge where MEM_BUSYWAIT is 0, and the request
// drops in the next cycle.
module data_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         CPU_READ,
  input  logic         CPU_WRITE,
  input  logic [31:0]  CPU_ADDRESS,
  input  logic [31:0]  CPU_WRITE_DATA,
  output logic [31:0]  CPU_READ_DATA,
  output logic         CPU_BUSYWAIT,
  output logic         MEM_READ,
  output logic         MEM_WRITE,
  output logic [27:0]  MEM_ADDRESS,
  output logic [127:0] MEM_WRITE_DATA,
  input  logic [127:0] MEM_READ_DATA,
  input  logic         MEM_BUSYWAIT,
  output logic [1:0]   debug_state
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    MEM_FETCH  = 2'd2,
    UPDATE     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mem_read_q, mem_read_d;
  logic                mem_write_q, mem_write_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic [LINES-1:0]    dirty_q, dirty_d;
  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [127:0]        data_q [LINES];

  // Next contents of the addressed line, written when line_we is set
  logic                line_we;
  logic [127:0]        line_d;
  logic [TAG_BITS-1:0] tag_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   addr_tag;
  logic [1:0]            word_sel;
  logic [1:0]            unused_addr_bits;
  logic                  req;
  logic                  hit;

  assign idx              = CPU_ADDRESS[3+INDEX_BITS:4];
  assign addr_tag         = CPU_ADDRESS[31:4+INDEX_BITS];
  assign word_sel         = CPU_ADDRESS[3:2];
  assign unused_addr_bits = CPU_ADDRESS[1:0];
  assign req              = CPU_READ | CPU_WRITE;
  assign hit              = valid_q[idx] && (tag_q[idx] == addr_tag);

  assign CPU_BUSYWAIT   = req && !((state_q == IDLE) && hit);
  assign CPU_READ_DATA  = data_q[idx][{word_sel, 5'b0} +: 32];
  assign MEM_READ       = mem_read_q;
  assign MEM_WRITE      = mem_write_q;
  // The victim address only matters during write-back; otherwise fetch the requested block
  assign MEM_ADDRESS    = (state_q == WRITE_BACK) ? {tag_q[idx], idx} : {addr_tag, idx};
  assign MEM_WRITE_DATA = data_q[idx];
  assign debug_state    = state_q;

  // Next-state, line update and registered memory request decode
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    line_we = 1'b0;
    line_d  = data_q[idx];
    tag_d   = tag_q[idx];
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // Both requests high is treated as a write
            if (CPU_WRITE) begin
              line_we                    = 1'b1;
              line_d[{word_sel, 5'b0} +: 32] = CPU_WRITE_DATA;
              dirty_d[idx]               = 1'b1;
            end
          end else if (valid_q[idx] && dirty_q[idx]) begin
            state_d = WRITE_BACK;
          end else begin
            state_d = MEM_FETCH;
          end
        end
      end
      WRITE_BACK: if (!MEM_BUSYWAIT) state_d = MEM_FETCH;
      MEM_FETCH:  if (!MEM_BUSYWAIT) state_d = UPDATE;
      UPDATE: begin
        // The block is complete only one cycle after MEM_BUSYWAIT falls
        line_we      = 1'b1;
        line_d       = MEM_READ_DATA;
        tag_d        = addr_tag;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    mem_read_d  = (state_d == MEM_FETCH);
    mem_write_d = (state_d == WRITE_BACK);
  end

  // FSM state, registered memory requests and line status bits
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      valid_q     <= '0;
      dirty_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
    end
  end

  // Line data and tag storage, deliberately not reset
  always_ff @(posedge CLOCK) begin
    if (line_we) begin
      data_q[idx] <= line_d;
      tag_q[idx]  <= tag_d;
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Bench for data_cache: a 16-cycle block memory model, a table of hit
// vectors, and hand-written miss / write-back / reset sequences.
module tb_data_cache;
  logic         CLOCK;
  logic         RESET;
  logic         CPU_READ;
  logic         CPU_WRITE;
  logic [31:0]  CPU_ADDRESS;
  logic [31:0]  CPU_WRITE_DATA;
  logic [31:0]  CPU_READ_DATA;
  logic         CPU_BUSYWAIT;
  logic         MEM_READ;
  logic         MEM_WRITE;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITE_DATA;
  logic [127:0] MEM_READ_DATA;
  logic         MEM_BUSYWAIT;
  logic [1:0]   debug_state;

  int checks = 0;
  int errors = 0;

  data_cache #(.INDEX_BITS(3)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .CPU_READ(CPU_READ),
    .CPU_WRITE(CPU_WRITE),
    .CPU_ADDRESS(CPU_ADDRESS),
    .CPU_WRITE_DATA(CPU_WRITE_DATA),
    .CPU_READ_DATA(CPU_READ_DATA),
    .CPU_BUSYWAIT(CPU_BUSYWAIT),
    .MEM_READ(MEM_READ),
    .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .MEM_READ_DATA(MEM_READ_DATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .debug_state(debug_state)
  );

  // Clock
  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // ---------------- memory model: 16 cycles per block ----------------
  logic [127:0] mem_store [logic [27:0]];
  logic [127:0] mem_rdata;
  int           mem_cnt;

  function automatic logic [127:0] read_block(input logic [27:0] ba);
    logic [127:0] b;
    if (mem_store.exists(ba)) return mem_store[ba];
    for (int w = 0; w < 4; w++) begin
      logic [1:0] wi;
      wi = w[1:0];
      b[w*32 +: 32] = 32'hA500_0000 ^ {ba, wi, 2'b00};
    end
    return b;
  endfunction

  assign MEM_BUSYWAIT  = (MEM_READ || MEM_WRITE) && (mem_cnt != 15);
  assign MEM_READ_DATA = mem_rdata;

  always @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      mem_cnt   <= 0;
      mem_rdata <= '0;
    end else if (MEM_READ || MEM_WRITE) begin
      if (mem_cnt == 15) begin
        mem_cnt <= 0;
        if (MEM_WRITE) mem_store[MEM_ADDRESS] = MEM_WRITE_DATA;
        else           mem_rdata <= read_block(MEM_ADDRESS);
      end else begin
        mem_cnt <= mem_cnt + 1;
      end
    end else begin
      mem_cnt <= 0;
    end
  end

  // ---------------- interface monitor ----------------
  logic         prev_rd, prev_wr;
  logic [27:0]  prev_addr;
  logic [127:0] prev_wdata;

  always @(negedge CLOCK) begin
    if (RESET) begin
      prev_rd = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (MEM_READ || MEM_WRITE) check("mem_exclusive", 128'(MEM_READ && MEM_WRITE), 128'(0));
      if (MEM_READ && prev_rd) check("rd_addr_stable", 128'(MEM_ADDRESS), 128'(prev_addr));
      if (MEM_WRITE && prev_wr) begin
        check("wr_addr_stable", 128'(MEM_ADDRESS), 128'(prev_addr));
        check("wr_data_stable", MEM_WRITE_DATA, prev_wdata);
      end
      prev_rd    = MEM_READ;
      prev_wr    = MEM_WRITE;
      prev_addr  = MEM_ADDRESS;
      prev_wdata = MEM_WRITE_DATA;
    end
  end

  // ---------------- driver: one full CPU access ----------------
  int           busy_n, rd_n, wr_n;
  logic [27:0]  rd_addr, wr_addr;
  logic [127:0] wr_data;
  logic [31:0]  rdata;

  // Called just after a posedge; returns just after the completing posedge
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
    logic done;
    done    = 1'b0;
    busy_n  = 0;
    rd_n    = 0;
    wr_n    = 0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    rdata   = '0;
    CPU_READ       = rd;
    CPU_WRITE      = wr;
    CPU_ADDRESS    = addr;
    CPU_WRITE_DATA = wdata;
    for (int c = 0; c < 200; c++) begin
      @(negedge CLOCK);
      if (MEM_READ)  begin rd_n++; rd_addr = MEM_ADDRESS; end
      if (MEM_WRITE) begin wr_n++; wr_addr = MEM_ADDRESS; wr_data = MEM_WRITE_DATA; end
      if (!CPU_BUSYWAIT) begin
        done  = 1'b1;
        rdata = CPU_READ_DATA;
        break;
      end
      busy_n++;
    end
    check("access_completes", 128'(done), 128'(1));
    @(posedge CLOCK);
    #1;
    CPU_READ  = 1'b0;
    CPU_WRITE = 1'b0;
  endtask

  // ---------------- hit vector table ----------------
  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_busy;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [9];

  initial begin
    // Line for block 0x4 holds A5000040/44/48/4C after the first miss
    vecs[0] = '{1'b1, 1'b0, 32'h44, 32'h0,         1'b0, 1'b1, 32'hA500_0044};
    vecs[1] = '{1'b1, 1'b0, 32'h4C, 32'h0,         1'b0, 1'b1, 32'hA500_004C};
    vecs[2] = '{1'b0, 1'b1, 32'h48, 32'hDEADBEEF,  1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h48, 32'h0,         1'b0, 1'b1, 32'hDEADBEEF};
    vecs[4] = '{1'b0, 1'b0, 32'h48, 32'h0,         1'b0, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 32'h4C, 32'h12345678,  1'b0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h4C, 32'h0,         1'b0, 1'b1, 32'h12345678};
    vecs[7] = '{1'b1, 1'b0, 32'h40, 32'h0,         1'b0, 1'b1, 32'hA500_0040};
    vecs[8] = '{1'b1, 1'b0, 32'h4B, 32'h0,         1'b0, 1'b1, 32'hDEADBEEF};

    // Reset
    RESET          = 1'b1;
    CPU_READ       = 1'b0;
    CPU_WRITE      = 1'b0;
    CPU_ADDRESS    = '0;
    CPU_WRITE_DATA = '0;
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;
    @(negedge CLOCK);
    check("reset_busywait", 128'(CPU_BUSYWAIT), 128'(0));
    check("reset_mem_read", 128'(MEM_READ), 128'(0));
    check("reset_mem_write", 128'(MEM_WRITE), 128'(0));
    check("reset_state", 128'(debug_state), 128'(0));
    @(posedge CLOCK);
    #1;

    // Clean read miss of 0x40
    do_access(1'b1, 1'b0, 32'h40, 32'h0);
    check("t1_busy_cycles", 128'(busy_n), 128'(18));
    check("t1_read_cycles", 128'(rd_n), 128'(16));
    check("t1_write_cycles", 128'(wr_n), 128'(0));
    check("t1_read_addr", 128'(rd_addr), 128'(28'h000_0004));
    check("t1_read_data", 128'(rdata), 128'(32'hA500_0040));

    // Hit vectors: no stall, no memory traffic
    for (int i = 0; i < 9; i++) begin
      CPU_READ       = vecs[i].rd;
      CPU_WRITE      = vecs[i].wr;
      CPU_ADDRESS    = vecs[i].addr;
      CPU_WRITE_DATA = vecs[i].wdata;
      @(negedge CLOCK);
      check($sformatf("vec%0d_busy", i), 128'(CPU_BUSYWAIT), 128'(vecs[i].exp_busy));
      check($sformatf("vec%0d_mem_read", i), 128'(MEM_READ), 128'(0));
      check($sformatf("vec%0d_mem_write", i), 128'(MEM_WRITE), 128'(0));
      if (vecs[i].chk_data)
        check($sformatf("vec%0d_data", i), 128'(CPU_READ_DATA), 128'(vecs[i].exp_data));
      @(posedge CLOCK);
      #1;
    end
    CPU_READ  = 1'b0;
    CPU_WRITE = 1'b0;

    // Dirty miss: same index, different tag
    do_access(1'b1, 1'b0, 32'h440, 32'h0);
    check("t4_busy_cycles", 128'(busy_n), 128'(34));
    check("t4_write_cycles", 128'(wr_n), 128'(16));
    check("t4_read_cycles", 128'(rd_n), 128'(16));
    check("t4_wb_addr", 128'(wr_addr), 128'(28'h000_0004));
    check("t4_wb_word2", 128'(wr_data[95:64]), 128'(32'hDEADBEEF));
    check("t4_wb_word3", 128'(wr_data[127:96]), 128'(32'h12345678));
    check("t4_wb_word0", 128'(wr_data[31:0]), 128'(32'hA500_0040));
    check("t4_fetch_addr", 128'(rd_addr), 128'(28'h000_0044));
    check("t4_read_data", 128'(rdata), 128'(32'hA500_0440));

    // Reset in the middle of a refill of 0x40
    CPU_READ    = 1'b1;
    CPU_ADDRESS = 32'h40;
    repeat (6) @(posedge CLOCK);
    #2;
    check("t5_fetch_state", 128'(debug_state), 128'(2));
    check("t5_fetch_mem_read", 128'(MEM_READ), 128'(1));
    RESET = 1'b1;
    #1;
    check("t5_reset_mem_read", 128'(MEM_READ), 128'(0));
    check("t5_reset_state", 128'(debug_state), 128'(0));
    CPU_READ = 1'b0;
    @(posedge CLOCK);
    #1 RESET = 1'b0;

    // Line is invalid again: 0x44 misses and refetches the written-back block
    do_access(1'b1, 1'b0, 32'h44, 32'h0);
    check("t5_busy_cycles", 128'(busy_n), 128'(18));
    check("t5_read_cycles", 128'(rd_n), 128'(16));
    check("t5_read_addr", 128'(rd_addr), 128'(28'h000_0004));
    check("t5_read_data", 128'(rdata), 128'(32'hA500_0044));

    // Written-back store survives the round trip through memory
    do_access(1'b1, 1'b0, 32'h48, 32'h0);
    check("t5b_busy_cycles", 128'(busy_n), 128'(0));
    check("t5b_read_cycles", 128'(rd_n), 128'(0));
    check("t5b_read_data", 128'(rdata), 128'(32'hDEADBEEF));

    repeat (2) @(posedge CLOCK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
